// File: rtl/piso_framer_pkg.sv
// Shared types, line levels and helpers for the parallel-in serial-out framer.
package piso_framer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    PARITY
  } state_t;

  localparam logic IDLE_LEVEL  = 1'b0;
  localparam logic START_LEVEL = 1'b1;

  // Widest word the parity helper accepts; narrower words are zero-extended.
  localparam int PAR_MAX_W = 64;

  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/piso_framer_if.sv
// Parallel-word valid/ready handshake between an upstream source and the framer.
interface piso_framer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;

  modport master (output din, output din_valid, input  din_ready);
  modport slave  (input  din, input  din_valid, output din_ready);
endinterface

// File: rtl/piso_framer.sv
// Serializes accepted parallel words into start bit + data bits + optional even parity,
// one bit per clock, with back-to-back frames when a word is ready in the final bit cycle.
module piso_framer
  import piso_framer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit PARITY_EN = 1'b1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  piso_framer_if.slave   in,
  output logic           dataout,
  output logic           busy,
  output logic           frame_done
);

  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

  state_t            state;
  logic [WIDTH-1:0]  shreg;
  logic [CNT_W-1:0]  cnt;
  logic              par_bit;

  logic [WIDTH-1:0]  din_w;
  logic [WIDTH-1:0]  shreg_next;
  logic              next_bit;
  logic              final_bit;
  logic              accept;

  assign din_w = in.din;

  // State names what dataout is carrying this cycle, so the final bit cycle is
  // known from state and counter alone and din_ready never depends on din_valid.
  assign final_bit    = PARITY_EN ? (state == PARITY) : (state == DATA && cnt == LAST_BIT);
  assign in.din_ready = (state == IDLE) || final_bit;
  assign accept       = in.din_valid && in.din_ready;

  assign next_bit   = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  assign shreg_next = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

  // NOTE: sequential state uses non-blocking assignments only; later assignments in
  // the same block (the acceptance override below) take priority over earlier ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      par_bit    <= 1'b0;
      dataout    <= IDLE_LEVEL;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: ;
        START: begin
          state   <= DATA;
          cnt     <= '0;
          dataout <= next_bit;
          shreg   <= shreg_next;
        end
        DATA: begin
          if (cnt != LAST_BIT) begin
            cnt     <= cnt + 1'b1;
            dataout <= next_bit;
            shreg   <= shreg_next;
          end else if (PARITY_EN) begin
            state   <= PARITY;
            dataout <= par_bit;
          end else begin
            state      <= IDLE;
            dataout    <= IDLE_LEVEL;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        PARITY: begin
          state      <= IDLE;
          dataout    <= IDLE_LEVEL;
          busy       <= 1'b0;
          frame_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase

      // Acceptance happens only in IDLE or the final bit cycle; it starts the next frame.
      if (accept) begin
        state   <= START;
        dataout <= START_LEVEL;
        busy    <= 1'b1;
        shreg   <= din_w;
        cnt     <= '0;
        par_bit <= even_parity(PAR_MAX_W'(din_w));
      end
    end
  end

endmodule

// File: tb/tb_piso_framer.sv
// Scoreboard bench: two framer configurations, expected serial frames queued at
// acceptance and compared cycle by cycle by independent monitors.
module tb_piso_framer;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  piso_framer_if #(.WIDTH(8)) if_a ();
  piso_framer_if #(.WIDTH(8)) if_b ();

  logic dout_a, busy_a, done_a;
  logic dout_b, busy_b, done_b;

  piso_framer #(.WIDTH(8), .PARITY_EN(1'b1), .MSB_FIRST(1'b1)) dut_a (
    .clk        (clk),
    .reset      (reset),
    .in         (if_a.slave),
    .dataout    (dout_a),
    .busy       (busy_a),
    .frame_done (done_a)
  );

  piso_framer #(.WIDTH(8), .PARITY_EN(1'b0), .MSB_FIRST(1'b0)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .in         (if_b.slave),
    .dataout    (dout_b),
    .busy       (busy_b),
    .frame_done (done_b)
  );

  int checks = 0;
  int fails  = 0;

  // Scoreboard state per instance (0 = parity/MSB-first, 1 = no parity/LSB-first).
  bit exp_bits [2][$];
  int exp_len  [2][$];
  int pos      [2];
  int cur_len  [2];
  bit done_pend[2];

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: start bit, data in the configured order, then even parity if enabled.
  task automatic push_frame(input int id, input logic [7:0] w);
    bit par_en = (id == 0);
    bit msb    = (id == 0);
    exp_bits[id].push_back(1'b1);
    for (int i = 0; i < 8; i++)
      exp_bits[id].push_back(w[msb ? 7 - i : i]);
    if (par_en)
      exp_bits[id].push_back(bit'($countones(w) % 2));
    exp_len[id].push_back(par_en ? 10 : 9);
  endtask

  task automatic mon_reset(input int id, input logic dout, input logic bsy,
                           input logic done, input logic rdy);
    check($sformatf("rst_dataout%0d", id), dout, 1'b0);
    check($sformatf("rst_busy%0d", id), bsy, 1'b0);
    check($sformatf("rst_frame_done%0d", id), done, 1'b0);
    check($sformatf("rst_din_ready%0d", id), rdy, 1'b1);
    exp_bits[id].delete();
    exp_len[id].delete();
    pos[id]       = 0;
    cur_len[id]   = 0;
    done_pend[id] = 1'b0;
  endtask

  task automatic mon_step(input int id, input logic dout, input logic bsy,
                          input logic done, input logic rdy);
    bit exp_busy = (exp_bits[id].size() != 0);
    check($sformatf("frame_done%0d", id), done, done_pend[id]);
    done_pend[id] = 1'b0;
    check($sformatf("busy%0d", id), bsy, exp_busy);
    if (exp_busy) begin
      if (pos[id] == 0) cur_len[id] = exp_len[id].pop_front();
      check($sformatf("dataout%0d_bit%0d", id, pos[id]), dout, exp_bits[id].pop_front());
      check($sformatf("din_ready%0d_bit%0d", id, pos[id]), rdy, pos[id] == cur_len[id] - 1);
      pos[id]++;
      if (pos[id] == cur_len[id]) begin
        pos[id]       = 0;
        done_pend[id] = 1'b1;
      end
    end else begin
      check($sformatf("idle_dataout%0d", id), dout, 1'b0);
      check($sformatf("idle_din_ready%0d", id), rdy, 1'b1);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) mon_reset(0, dout_a, busy_a, done_a, if_a.din_ready);
    else        mon_step (0, dout_a, busy_a, done_a, if_a.din_ready);
  end

  always @(negedge clk) begin
    if (!reset) mon_reset(1, dout_b, busy_b, done_b, if_b.din_ready);
    else        mon_step (1, dout_b, busy_b, done_b, if_b.din_ready);
  end

  task automatic set_valid(input int id, input logic v);
    if (id == 0) if_a.din_valid = v;
    else         if_b.din_valid = v;
  endtask

  // Offer a word, wait (bounded) for din_ready, and queue its frame at the accepting edge.
  task automatic send(input int id, input logic [7:0] w, input bit hold);
    int n = 0;
    if (id == 0) if_a.din = w;
    else         if_b.din = w;
    set_valid(id, 1'b1);
    @(negedge clk);
    while (!(id == 0 ? if_a.din_ready : if_b.din_ready)) begin
      n++;
      if (n > 50) begin
        checks++;
        fails++;
        $display("FAIL accept_timeout%0d: word %h never accepted", id, w);
        set_valid(id, 1'b0);
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    push_frame(id, w);
    #1;
    if (!hold) set_valid(id, 1'b0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_bits[0].size() != 0 || exp_bits[1].size() != 0 ||
           done_pend[0] || done_pend[1]) begin
      n++;
      if (n > 100) begin
        checks++;
        fails++;
        $display("FAIL drain_timeout: frames still pending");
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b0;
    if_a.din       = 8'h55;
    if_b.din       = 8'h55;
    if_a.din_valid = 1'b1;
    if_b.din_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if_a.din_valid = 1'b0;
    if_b.din_valid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;

    // Single parity frame, MSB first.
    send(0, 8'hF6, 1'b0);
    wait_idle();

    // Back-to-back frames with valid held high.
    send(0, 8'hA5, 1'b1);
    send(0, 8'h3C, 1'b0);
    wait_idle();

    // New word offered during DATA must wait for the parity cycle.
    send(0, 8'h81, 1'b1);
    send(0, 8'h00, 1'b0);
    wait_idle();

    // Reset during the 4th data bit aborts the frame without frame_done.
    send(0, 8'hFF, 1'b0);
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_dataout", dout_a, 1'b0);
    check("abort_busy", busy_a, 1'b0);
    check("abort_frame_done", done_a, 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    send(0, 8'h0F, 1'b0);
    wait_idle();

    // No parity, LSB first.
    send(1, 8'h01, 1'b0);
    wait_idle();

    // Randomized bursts on either instance with random idle gaps.
    repeat (30) begin
      int id    = int'($urandom_range(0, 1));
      int burst = int'($urandom_range(1, 3));
      for (int k = 0; k < burst; k++)
        send(id, 8'($urandom), k != burst - 1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_idle();
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
